// File: rtl/instr_pkg.sv
// ============================================================================
// Module      : instr_pkg
// Description : Shared constants for the 13-bit instruction format: kind
//               codes, field bit positions, fixed prefixes and the NOP word.
//               Imported by the encoder, and by decode logic elsewhere.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_pkg;

  localparam int c_instr_w = 13;

  // Instruction class carried on kind_i
  typedef enum logic [1:0] {
    KIND_ALU    = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_IMM    = 2'b10,
    KIND_NOP    = 2'b11
  } kind_e;

  // ALU word: {0, opcode[2:0], a[2:0], b[2:0], dst[2:0]}
  localparam int c_alu_opc_lsb = 9;
  localparam int c_alu_a_lsb   = 6;
  localparam int c_alu_b_lsb   = 3;
  localparam int c_dst_lsb     = 0;

  // IMM word: {1010, imm[5:0], dst[2:0]}
  localparam int c_imm_lsb     = 3;
  localparam int c_imm_w       = 6;

  // BRANCH word: {100, 0, 00, addr[6:0]}
  localparam int c_br_addr_lsb = 0;
  localparam int c_br_addr_w   = 7;

  localparam logic [2:0]           c_branch_prefix = 3'b100;
  localparam logic [3:0]           c_imm_prefix    = 4'b1010;
  localparam logic [c_instr_w-1:0] c_nop_word      = 13'h1800;

endpackage : instr_pkg

`default_nettype wire

// File: rtl/instr_field_packer.sv
// ============================================================================
// Module      : instr_field_packer
// Description : Purely combinational packer. Maps an instruction kind and
//               its separate fields onto one 13-bit instruction word and
//               flags fields that cannot be encoded.
//               Macro INSTR_ENC_CHECK_EN enables range checking: an
//               out-of-range IMM or BRANCH field yields the NOP word and
//               raises range_err_o. Without it, imm is truncated to 6 bits
//               and range_err_o is tied low.
// Ports       : kind_i, opcode_i, op_a_i, op_b_i, dst_i, imm_i,
//               branch_addr_i  - instruction fields
//               word_o         - encoded instruction
//               range_err_o    - field out of encodable range
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_packer
  import instr_pkg::*;
`ifdef INSTR_ENC_CHECK_EN
#(
  parameter int PROG_DEPTH = 128
)
`endif
(
  input  logic [1:0]           kind_i,
  input  logic [2:0]           opcode_i,
  input  logic [2:0]           op_a_i,
  input  logic [2:0]           op_b_i,
  input  logic [2:0]           dst_i,
  input  logic [7:0]           imm_i,
  input  logic [6:0]           branch_addr_i,
  output logic [c_instr_w-1:0] word_o,
  output logic                 range_err_o
);

  logic w_bad_field;

`ifdef INSTR_ENC_CHECK_EN
  always_comb begin
    w_bad_field = 1'b0;
    case (kind_e'(kind_i))
      KIND_IMM:    w_bad_field = |imm_i[7:c_imm_w];
      KIND_BRANCH: w_bad_field = (int'(branch_addr_i) >= PROG_DEPTH);
      default:     w_bad_field = 1'b0;
    endcase
  end
`else
  // Upper immediate bits are deliberately dropped in the unchecked build.
  logic w_unused_imm_hi;
  assign w_unused_imm_hi = ^imm_i[7:c_imm_w];
  assign w_bad_field     = 1'b0;
`endif

  always_comb begin
    word_o = c_nop_word;
    case (kind_e'(kind_i))
      KIND_ALU: begin
        word_o = '0;
        word_o[c_alu_opc_lsb +: 3] = opcode_i;
        word_o[c_alu_a_lsb   +: 3] = op_a_i;
        word_o[c_alu_b_lsb   +: 3] = op_b_i;
        word_o[c_dst_lsb     +: 3] = dst_i;
      end
      KIND_BRANCH: begin
        word_o = '0;
        word_o[c_instr_w-1 -: 3]                = c_branch_prefix;
        word_o[c_br_addr_lsb +: c_br_addr_w]    = branch_addr_i;
      end
      KIND_IMM: begin
        word_o = '0;
        word_o[c_instr_w-1 -: 4]          = c_imm_prefix;
        word_o[c_imm_lsb +: c_imm_w]      = imm_i[c_imm_w-1:0];
        word_o[c_dst_lsb +: 3]            = dst_i;
      end
      default: word_o = c_nop_word;
    endcase
    // An unencodable field is replaced by a harmless NOP.
    if (w_bad_field) begin
      word_o = c_nop_word;
    end
  end

  assign range_err_o = w_bad_field;

endmodule : instr_field_packer

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module      : instr_encoder_loader
// Description : Program-load block. Accepts instruction field bundles over
//               valid/ready, packs each into a 13-bit word and writes the
//               words to program memory at consecutive addresses from 0.
//               One word every two cycles at best (accept, then write).
//               Macro INSTR_ENC_CHECK_EN enables field range checking in
//               the packer; range errors set err_o but the load continues.
// Ports       : clk_i, rst_n_i          - clock, async active-low reset
//               start_i                 - begin a load (IDLE only)
//               valid_i/ready_o/last_i  - bundle handshake
//               kind_i..branch_addr_i   - instruction fields
//               mem_wr_en_o/addr/data   - program-memory write port
//               busy_o, done_o, count_o, err_o - status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int PROG_DEPTH = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 last_i,
  input  logic [1:0]           kind_i,
  input  logic [2:0]           opcode_i,
  input  logic [2:0]           op_a_i,
  input  logic [2:0]           op_b_i,
  input  logic [2:0]           dst_i,
  input  logic [7:0]           imm_i,
  input  logic [6:0]           branch_addr_i,
  output logic                 mem_wr_en_o,
  output logic [6:0]           mem_addr_o,
  output logic [c_instr_w-1:0] mem_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           count_o,
  output logic                 err_o
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_write = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [6:0] c_last_addr = 7'(PROG_DEPTH - 1);

  logic [1:0]           r_state;
  logic [6:0]           r_addr;
  logic [c_instr_w-1:0] r_data;
  logic                 r_last;
  logic [7:0]           r_count;
  logic                 r_err;

  logic [c_instr_w-1:0] w_word;
  logic                 w_range_err;
  logic                 w_at_top;

  instr_field_packer
`ifdef INSTR_ENC_CHECK_EN
    #(.PROG_DEPTH(PROG_DEPTH))
`endif
  u_packer (
    .kind_i        (kind_i),
    .opcode_i      (opcode_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .dst_i         (dst_i),
    .imm_i         (imm_i),
    .branch_addr_i (branch_addr_i),
    .word_o        (w_word),
    .range_err_o   (w_range_err)
  );

  assign w_at_top = (r_addr == c_last_addr);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= c_st_idle;
      r_addr  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start_i) begin
            r_state <= c_st_load;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        c_st_load: begin
          if (valid_i) begin
            r_data  <= w_word;
            r_last  <= last_i;
            r_state <= c_st_write;
            if (w_range_err) begin
              r_err <= 1'b1;
            end
          end
        end
        c_st_write: begin
          r_count <= r_count + 8'd1;
          // The address saturates at the top of memory; it never wraps.
          if (!w_at_top) begin
            r_addr <= r_addr + 7'd1;
          end
          if (r_last || w_at_top) begin
            r_state <= c_st_done;
            // Filling the last location without a final marker is overflow.
            if (!r_last) begin
              r_err <= 1'b1;
            end
          end else begin
            r_state <= c_st_load;
          end
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  // Strobes decode directly from the state register, so an asynchronous
  // reset drops mem_wr_en_o at once and no partial write can reach memory.
  assign ready_o     = (r_state == c_st_load);
  assign mem_wr_en_o = (r_state == c_st_write);
  assign done_o      = (r_state == c_st_done);
  assign busy_o      = (r_state != c_st_idle);
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_data;
  assign count_o     = r_count;
  assign err_o       = r_err;

endmodule : instr_encoder_loader

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Directed self-checking bench for instr_encoder_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        valid_i;
  logic        ready_o;
  logic        last_i;
  logic [1:0]  kind_i;
  logic [2:0]  opcode_i;
  logic [2:0]  op_a_i;
  logic [2:0]  op_b_i;
  logic [2:0]  dst_i;
  logic [7:0]  imm_i;
  logic [6:0]  branch_addr_i;
  logic        mem_wr_en_o;
  logic [6:0]  mem_addr_o;
  logic [12:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  count_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  instr_encoder_loader dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (start_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .last_i        (last_i),
    .kind_i        (kind_i),
    .opcode_i      (opcode_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .dst_i         (dst_i),
    .imm_i         (imm_i),
    .branch_addr_i (branch_addr_i),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .count_o       (count_o),
    .err_o         (err_o)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Waits (bounded) for ready, presents one bundle for one cycle and
  // returns in the cycle that follows the handshake (the write cycle).
  task automatic drive_bundle(input logic [1:0] k, input logic [2:0] opc,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] d, input logic [7:0] im,
                              input logic [6:0] br, input logic lst);
    int n = 0;
    while (ready_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout: ready_o=%b required 1", ready_o);
    end
    kind_i = k; opcode_i = opc; op_a_i = a; op_b_i = b; dst_i = d;
    imm_i = im; branch_addr_i = br; last_i = lst;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    start_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({ready_o, mem_wr_en_o, mem_addr_o, mem_data_o, busy_o, done_o, count_o, err_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b cnt=%0d err=%b required all 0",
               ready_o, mem_wr_en_o, mem_addr_o, mem_data_o, busy_o, done_o, count_o, err_o);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    do_start();
    checks++;
    if ({ready_o, busy_o} !== 2'b11) begin
      failures++;
      $display("FAIL alu_start_ready: ready=%b busy=%b required 1 1", ready_o, busy_o);
    end
    drive_bundle(2'b00, 3'd3, 3'd5, 3'd2, 3'd7, 8'h00, 7'h00, 1'b1);
    checks++;
    if ({mem_wr_en_o, ready_o, mem_addr_o, mem_data_o} !== {1'b1, 1'b0, 7'd0, 13'h0757}) begin
      failures++;
      $display("FAIL alu_write: we=%b rdy=%b addr=%0d data=%h required 1 0 0 0757",
               mem_wr_en_o, ready_o, mem_addr_o, mem_data_o);
    end
    tick();
    checks++;
    if ({done_o, mem_wr_en_o, count_o, err_o} !== {1'b1, 1'b0, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL alu_done: done=%b we=%b cnt=%0d err=%b required 1 0 1 0",
               done_o, mem_wr_en_o, count_o, err_o);
    end
    tick();
    checks++;
    if ({done_o, busy_o, count_o, mem_data_o} !== {1'b0, 1'b0, 8'd1, 13'h0757}) begin
      failures++;
      $display("FAIL alu_idle_hold: done=%b busy=%b cnt=%0d data=%h required 0 0 1 0757",
               done_o, busy_o, count_o, mem_data_o);
    end
  endtask

  task automatic test_imm_branch();
    do_start();
    drive_bundle(2'b10, 3'd0, 3'd0, 3'd0, 3'd3, 8'h2A, 7'h00, 1'b0);
    checks++;
    if ({mem_wr_en_o, mem_addr_o, mem_data_o} !== {1'b1, 7'd0, 13'h1553}) begin
      failures++;
      $display("FAIL imm_write: we=%b addr=%0d data=%h required 1 0 1553",
               mem_wr_en_o, mem_addr_o, mem_data_o);
    end
    tick();
    drive_bundle(2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 7'h45, 1'b1);
    checks++;
    if ({mem_wr_en_o, mem_addr_o, mem_data_o} !== {1'b1, 7'd1, 13'h1045}) begin
      failures++;
      $display("FAIL branch_write: we=%b addr=%0d data=%h required 1 1 1045",
               mem_wr_en_o, mem_addr_o, mem_data_o);
    end
    tick();
    checks++;
    if ({done_o, count_o, err_o} !== {1'b1, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL imm_branch_done: done=%b cnt=%0d err=%b required 1 2 0",
               done_o, count_o, err_o);
    end
    tick();
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 128; i++) begin
      drive_bundle(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 7'h00, 1'b0);
      checks++;
      if ({mem_wr_en_o, mem_addr_o, mem_data_o} !== {1'b1, 7'(i), 13'h1800}) begin
        failures++;
        $display("FAIL ovf_write[%0d]: we=%b addr=%0d data=%h required 1 %0d 1800",
                 i, mem_wr_en_o, mem_addr_o, mem_data_o, i);
      end
      tick();
    end
    checks++;
    if ({done_o, err_o, ready_o, mem_wr_en_o, count_o} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd128}) begin
      failures++;
      $display("FAIL ovf_done: done=%b err=%b rdy=%b we=%b cnt=%0d required 1 1 0 0 128",
               done_o, err_o, ready_o, mem_wr_en_o, count_o);
    end
    // Keep offering bundles: nothing may be accepted or written.
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ready_o, mem_wr_en_o, busy_o, mem_addr_o, err_o} !== {1'b0, 1'b0, 1'b0, 7'd127, 1'b1}) begin
        failures++;
        $display("FAIL ovf_no_wrap[%0d]: rdy=%b we=%b busy=%b addr=%0d err=%b required 0 0 0 127 1",
                 i, ready_o, mem_wr_en_o, busy_o, mem_addr_o, err_o);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_range();
    logic [12:0] exp_data;
    logic        exp_err;
`ifdef INSTR_ENC_CHECK_EN
    exp_data = 13'h1800;
    exp_err  = 1'b1;
`else
    exp_data = 13'h140D;
    exp_err  = 1'b0;
`endif
    do_start();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL start_clears_err: err=%b required 0", err_o);
    end
    drive_bundle(2'b10, 3'd0, 3'd0, 3'd0, 3'd5, 8'hC1, 7'h00, 1'b1);
    checks++;
    if ({mem_wr_en_o, mem_addr_o, mem_data_o} !== {1'b1, 7'd0, exp_data}) begin
      failures++;
      $display("FAIL range_write: we=%b addr=%0d data=%h required 1 0 %h",
               mem_wr_en_o, mem_addr_o, mem_data_o, exp_data);
    end
    tick();
    checks++;
    if ({done_o, err_o} !== {1'b1, exp_err}) begin
      failures++;
      $display("FAIL range_err: done=%b err=%b required 1 %b", done_o, err_o, exp_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_start();
    drive_bundle(2'b00, 3'd1, 3'd1, 3'd1, 3'd1, 8'h00, 7'h00, 1'b0);
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ready_o, mem_wr_en_o, mem_addr_o, mem_data_o, busy_o, done_o, count_o, err_o} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b cnt=%0d err=%b required all 0",
               ready_o, mem_wr_en_o, mem_addr_o, mem_data_o, busy_o, done_o, count_o, err_o);
    end
    tick();
    checks++;
    if (mem_wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_write: we=%b required 0", mem_wr_en_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    do_start();
    drive_bundle(2'b00, 3'd3, 3'd5, 3'd2, 3'd7, 8'h00, 7'h00, 1'b1);
    checks++;
    if ({mem_wr_en_o, mem_addr_o, mem_data_o} !== {1'b1, 7'd0, 13'h0757}) begin
      failures++;
      $display("FAIL midreset_restart: we=%b addr=%0d data=%h required 1 0 0757",
               mem_wr_en_o, mem_addr_o, mem_data_o);
    end
    tick();
    checks++;
    if ({done_o, count_o} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL midreset_count: done=%b cnt=%0d required 1 1", done_o, count_o);
    end
    tick();
  endtask

  task automatic test_ignore();
    valid_i = 1'b1;
    kind_i  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ready_o, mem_wr_en_o, busy_o, count_o} !== {1'b0, 1'b0, 1'b0, 8'd1}) begin
        failures++;
        $display("FAIL idle_valid[%0d]: rdy=%b we=%b busy=%b cnt=%0d required 0 0 0 1",
                 i, ready_o, mem_wr_en_o, busy_o, count_o);
      end
    end
    valid_i = 1'b0;
    do_start();
    drive_bundle(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 7'h00, 1'b0);
    tick();
    do_start();
    checks++;
    if ({ready_o, mem_addr_o, count_o} !== {1'b1, 7'd1, 8'd1}) begin
      failures++;
      $display("FAIL load_start_ignored: rdy=%b addr=%0d cnt=%0d required 1 1 1",
               ready_o, mem_addr_o, count_o);
    end
    drive_bundle(2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 7'h12, 1'b1);
    checks++;
    if ({mem_wr_en_o, mem_addr_o, mem_data_o} !== {1'b1, 7'd1, 13'h1012}) begin
      failures++;
      $display("FAIL ignore_second_write: we=%b addr=%0d data=%h required 1 1 1012",
               mem_wr_en_o, mem_addr_o, mem_data_o);
    end
    tick();
    checks++;
    if ({done_o, count_o} !== {1'b1, 8'd2}) begin
      failures++;
      $display("FAIL ignore_done: done=%b cnt=%0d required 1 2", done_o, count_o);
    end
    tick();
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
    kind_i = '0; opcode_i = '0; op_a_i = '0; op_b_i = '0; dst_i = '0;
    imm_i = '0; branch_addr_i = '0;
    test_reset();
    test_alu();
    test_imm_branch();
    test_overflow();
    test_range();
    test_reset_mid();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_encoder_loader

`default_nettype wire
